packetizer: RTL and testbench
=============================

Name: packetizer

Overview:
- Transmit-side framer for the sequenced stream protocol that the parser consumes.
- Accepts one payload request (up to 37 bytes, stream id) and assigns the next per-stream sequence number.
- Emits the framed 32-bit word stream: length/stream header word, sequence word, then payload words with last flag.
- Sits at the send end of the link; its dataOut/dataOut_val/dataOut_ready/dataOut_last connect directly to a parser's dataIn/dataIn_val/dataIn_ready/dataIN_last.

Parameters:
NUM_STREAMS, 32, number of independent sequence counters; stream id width SW = $clog2(NUM_STREAMS)
MAX_PAYLOAD_BYTES, 37, largest legal payload; payload bus width is 8*MAX_PAYLOAD_BYTES
HDR_BYTES, 8, header size (length/stream word plus sequence word), counted in the length field

Ports:
clk  in  1  clock
reset_b  in  1  reset, asynchronous, active-low
payloadIn  in  [0:295]  payload bytes, byte k at bits [8k:8k+7], byte 0 sent first
payloadLen  in  6  payload byte count, legal range 1..37
streamId  in  SW  target stream
payloadIn_val  in  1  request valid
payloadIn_ready  out  1  request accepted when val&ready
dataOut  out  32  framed word
dataOut_val  out  1  word valid
dataOut_ready  in  1  sink accepts word when val&ready
dataOut_last  out  1  final word of packet
reqDropped  out  1  one-cycle pulse: illegal request discarded

Behaviour:
- Reset, asynchronous on reset_b low:
  - state=IDLE; all outputs 0 except payloadIn_ready=1; all sequence counters 0; latched request registers 0.
  - Reset mid-packet abandons the packet immediately with no further words.
- States:
  - IDLE: payloadIn_ready=1, dataOut_val=0.
    - On val with payloadLen in 1..37: latch payload, length and stream, then go to HDR0.
    - On val with payloadLen 0 or >37: stay in IDLE, pulse reqDropped next cycle, leave counters untouched.
  - HDR0: drives word 0; advances to HDR1 on dataOut_ready.
  - HDR1: drives the sequence word and captures words = ceil(len/4), 1..10; advances to DATA on dataOut_ready.
  - DATA: drives payload word i (i from 0); i increments on each handshake.
    - dataOut_last=1 on i==words-1.
    - The last handshake returns to IDLE and increments seq[stream].
- payloadIn_ready is 1 only in IDLE, so there is one idle cycle between packets.
- Latency: request accepted at cycle N puts word 0 valid at N+1. Minimum packet duration is 2+words cycles.
- Word encoding (all fields byte-swapped little-endian):
  - Word 0: L = payloadLen + 8. [31:24]=L[7:0], [23:16]=L[15:8], [15:8]=stream[7:0], [7:0]=stream[15:8]. Stream is zero-extended to 16 bits.
  - Word 1: S = seq[stream]. [31:24]=S[7:0], [23:16]=S[15:8], [15:8]=S[23:16], [7:0]=S[31:24].
  - Payload word i: bytes 4i..4i+3 placed in [31:24], [23:16], [15:8], [7:0].
  - Bytes at or beyond payloadLen are driven 0, matching the receiver's masking.
- Sequence counters:
  - 32-bit per stream, reset to 0, so the first packet of each stream carries seq 0.
  - Wrap 0xFFFFFFFF to 0.
  - Updated only at the last-word handshake.
- Output registers:
  - dataOut and dataOut_last are registered and held stable while dataOut_val & !dataOut_ready.
  - dataOut is 0 whenever dataOut_val=0.
- payloadIn and streamId are don't-care outside the accept cycle.

Decomposition:
- parser_pkg:
  - tx_state_t enum {IDLE, HDR0, HDR1, DATA}.
  - Constants HDR_BYTES, MAX_PAYLOAD_BYTES, NUM_STREAMS.
  - Functions bswap16 and bswap32, shared with the parser.
- Sub-module seq_table:
  - NUM_STREAMS x 32 register file.
  - Combinational read by stream id.
  - Synchronous increment-write port.
  - Async reset clears all entries.

Test Plan:
- Stream 3, len 5, bytes 11 22 33 44 55, ready=1 → words 0x0D000300, 0x00000000, 0x11223344, 0x55000000; last on word 4 only.
- Second packet on stream 3, then first packet on stream 7 → seq words 0x01000000 and 0x00000000.
- len 37 on stream 0 → word0 0x2D000000, then 10 payload words; word 12 has only [31:24] nonzero; last on word 12.
- dataOut_ready low 3 cycles during DATA word 1 → dataOut, val and last held constant; no word skipped or duplicated.
- len 0, then len 38 → reqDropped pulses, no dataOut_val, stream counter unchanged; the next legal packet still gets seq 0.
- reset_b low mid-DATA → dataOut_val=0 immediately. Loopback into parser after reset: packetLost=0 for seqs 0,1,2 on one stream; skipping via reset shows no loss since both ends restart.

Source files
------------

// File: rtl/packetizer_pkg.sv
`timescale 1ns/1ps
// Shared types, sizes and byte-order helpers for the sequenced stream framer.
package packetizer_pkg;

  localparam int NUM_STREAMS       = 32;
  localparam int MAX_PAYLOAD_BYTES = 37;
  localparam int HDR_BYTES         = 8;
  localparam int SW                = $clog2(NUM_STREAMS);
  localparam int PAYLOAD_W         = 8 * MAX_PAYLOAD_BYTES;
  localparam int MAX_WORDS         = (MAX_PAYLOAD_BYTES + 3) / 4;
  // Payload storage is padded to whole words so every word select stays in range.
  localparam int PAD_W             = 32 * MAX_WORDS;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} tx_state_t;

  // Little-endian byte order on the wire: least significant byte goes to [15:8].
  function automatic logic [15:0] bswap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/packetizer_if.sv
`timescale 1ns/1ps
// Request and framed-word bus of the packetizer; slave side is the framer itself.
interface packetizer_if;
  import packetizer_pkg::*;

  logic [0:PAYLOAD_W-1] payloadIn;
  logic [5:0]           payloadLen;
  logic [SW-1:0]        streamId;
  logic                 payloadIn_val;
  logic                 payloadIn_ready;
  logic [31:0]          dataOut;
  logic                 dataOut_val;
  logic                 dataOut_ready;
  logic                 dataOut_last;
  logic                 reqDropped;

  modport master (
    output payloadIn, payloadLen, streamId, payloadIn_val, dataOut_ready,
    input  payloadIn_ready, dataOut, dataOut_val, dataOut_last, reqDropped
  );

  modport slave (
    input  payloadIn, payloadLen, streamId, payloadIn_val, dataOut_ready,
    output payloadIn_ready, dataOut, dataOut_val, dataOut_last, reqDropped
  );

endinterface

// File: rtl/packetizer_seq_table.sv
`timescale 1ns/1ps
// Per-stream 32-bit sequence counters: combinational read, increment-only write.
module seq_table #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic [IW-1:0] i_rd_id,
  output logic [31:0]   o_rd_seq,
  input  logic          i_inc_en,
  input  logic [IW-1:0] i_inc_id
);

  logic [31:0] r_seq [N];

  assign o_rd_seq = r_seq[i_rd_id];

  // Clear every counter on reset; bump the addressed one (wrapping naturally) on request.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < N; i++) r_seq[i] <= 32'd0;
    end else if (i_inc_en) begin
      r_seq[i_inc_id] <= r_seq[i_inc_id] + 32'd1;
    end
  end

endmodule

// File: rtl/packetizer.sv
`timescale 1ns/1ps
// Transmit framer: header word, sequence word, then payload words with last flag.
module packetizer
  import packetizer_pkg::*;
(
  input  logic         clk,
  input  logic         reset_b,
  packetizer_if.slave  bus
);

  tx_state_t          r_state;
  logic [0:PAD_W-1]   r_payload;
  logic [5:0]         r_len;
  logic [SW-1:0]      r_stream;
  logic [3:0]         r_words;
  logic [3:0]         r_idx;
  logic [31:0]        r_data;
  logic               r_val;
  logic               r_last;
  logic               r_ready;
  logic               r_drop;

  logic [0:PAD_W-1]   w_masked;
  logic [31:0]        w_word [MAX_WORDS];
  logic [31:0]        w_seq;
  logic [31:0]        w_hdr0;
  logic [3:0]         w_words_calc;
  logic [3:0]         w_sel_idx;
  logic [31:0]        w_sel_word;
  logic               w_len_ok;
  logic               w_done;

  // Bytes at or beyond the payload length are zeroed when latched, so the
  // word selects below never need to mask.
  genvar gi;
  generate
    for (gi = 0; gi < 4 * MAX_WORDS; gi++) begin : g_mask
      if (gi < MAX_PAYLOAD_BYTES) begin : g_real
        assign w_masked[8*gi +: 8] = (6'(gi) < bus.payloadLen) ? bus.payloadIn[8*gi +: 8] : 8'h00;
      end else begin : g_pad
        assign w_masked[8*gi +: 8] = 8'h00;
      end
    end
    for (gi = 0; gi < MAX_WORDS; gi++) begin : g_words
      assign w_word[gi] = r_payload[32*gi +: 32];
    end
  endgenerate

  assign w_len_ok     = (bus.payloadLen != 6'd0) && (bus.payloadLen <= 6'(MAX_PAYLOAD_BYTES));
  assign w_hdr0       = {bswap16(16'(bus.payloadLen) + 16'(HDR_BYTES)), bswap16(16'(bus.streamId))};
  assign w_words_calc = 4'((7'(r_len) + 7'd3) >> 2);
  // HDR1 loads payload word 0; DATA loads the word after the one being sent.
  assign w_sel_idx    = (r_state == HDR1) ? 4'd0 : r_idx + 4'd1;
  assign w_sel_word   = (w_sel_idx < 4'(MAX_WORDS)) ? w_word[w_sel_idx] : 32'd0;
  assign w_done       = (r_state == DATA) && r_val && r_last && bus.dataOut_ready;

  seq_table #(.N(NUM_STREAMS)) u_seq_table (
    .clk      (clk),
    .reset_b  (reset_b),
    .i_rd_id  (r_stream),
    .o_rd_seq (w_seq),
    .i_inc_en (w_done),
    .i_inc_id (r_stream)
  );

  // Framing FSM; every output is a register loaded one word ahead of its handshake.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= IDLE;
      r_payload <= '0;
      r_len     <= '0;
      r_stream  <= '0;
      r_words   <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_val     <= 1'b0;
      r_last    <= 1'b0;
      r_ready   <= 1'b1;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.payloadIn_val) begin
            if (w_len_ok) begin
              r_payload <= w_masked;
              r_len     <= bus.payloadLen;
              r_stream  <= bus.streamId;
              r_data    <= w_hdr0;
              r_val     <= 1'b1;
              r_last    <= 1'b0;
              r_ready   <= 1'b0;
              r_state   <= HDR0;
            end else begin
              r_drop <= 1'b1;
            end
          end
        end
        HDR0: begin
          if (bus.dataOut_ready) begin
            r_data  <= bswap32(w_seq);
            r_state <= HDR1;
          end
        end
        HDR1: begin
          if (bus.dataOut_ready) begin
            r_words <= w_words_calc;
            r_idx   <= 4'd0;
            r_data  <= w_sel_word;
            r_last  <= (w_words_calc == 4'd1);
            r_state <= DATA;
          end
        end
        DATA: begin
          if (bus.dataOut_ready) begin
            if (r_last) begin
              r_data  <= 32'd0;
              r_val   <= 1'b0;
              r_last  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_data <= w_sel_word;
              r_idx  <= r_idx + 4'd1;
              r_last <= ((r_idx + 4'd2) == r_words);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.payloadIn_ready = r_ready;
  assign bus.dataOut         = r_data;
  assign bus.dataOut_val     = r_val;
  assign bus.dataOut_last    = r_last;
  assign bus.reqDropped      = r_drop;

endmodule

// File: tb/tb_packetizer.sv
`timescale 1ns/1ps
// Self-checking bench for packetizer: directed and random packets against a byte-level model.
module tb_packetizer;
  import packetizer_pkg::*;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  packetizer_if ifc();

  packetizer dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;
  int pkt_no   = 0;
  logic [31:0] model_seq [NUM_STREAMS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_STREAMS; i++) model_seq[i] = 32'd0;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) ifc.payloadIn[8*i +: 8] = 8'($urandom);
    ifc.streamId   = SW'($urandom);
    ifc.payloadLen = 6'($urandom);
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stall on DATA word 1
  task automatic run_packet(input int len, input int stream, input int mode);
    logic [7:0]  b [40];
    logic [31:0] exp_q [$];
    logic [15:0] l16, s16;
    logic [31:0] s, word, prev_data;
    logic        rdy, prev_stall, prev_last;
    int          n, k, cyc, stall_cnt;
    for (int i = 0; i < 40; i++) b[i] = 8'($urandom);
    l16 = 16'(len + HDR_BYTES);
    s16 = 16'(stream);
    s   = model_seq[stream];
    exp_q.push_back({l16[7:0], l16[15:8], s16[7:0], s16[15:8]});
    exp_q.push_back({s[7:0], s[15:8], s[23:16], s[31:24]});
    for (int w = 0; w < (len + 3) / 4; w++) begin
      word = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4*w + j < len) word[31 - 8*j -: 8] = b[4*w + j];
      exp_q.push_back(word);
    end
    n = exp_q.size();
    pkt_no++;

    @(negedge clk);
    check($sformatf("req_ready_p%0d", pkt_no), 32'(ifc.payloadIn_ready), 32'd1);
    for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) ifc.payloadIn[8*i +: 8] = b[i];
    ifc.payloadLen    = 6'(len);
    ifc.streamId      = SW'(stream);
    ifc.payloadIn_val = 1'b1;
    @(negedge clk);
    ifc.payloadIn_val = 1'b0;
    scramble_inputs();
    check($sformatf("latency_p%0d", pkt_no), 32'(ifc.dataOut_val), 32'd1);

    k = 0; cyc = 0; stall_cnt = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (k < n && cyc < 100) begin
      if (prev_stall) begin
        check($sformatf("hold_data_p%0d_w%0d", pkt_no, k), ifc.dataOut, prev_data);
        check($sformatf("hold_last_p%0d_w%0d", pkt_no, k), 32'(ifc.dataOut_last), 32'(prev_last));
      end
      check($sformatf("val_p%0d_w%0d", pkt_no, k), 32'(ifc.dataOut_val), 32'd1);
      case (mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2: begin
          if (k == 3 && stall_cnt < 3) begin rdy = 1'b0; stall_cnt++; end
          else rdy = 1'b1;
        end
        default: rdy = 1'b1;
      endcase
      ifc.dataOut_ready = rdy;
      if (ifc.dataOut_val && rdy) begin
        check($sformatf("word_p%0d_w%0d", pkt_no, k), ifc.dataOut, exp_q[k]);
        check($sformatf("last_p%0d_w%0d", pkt_no, k), 32'(ifc.dataOut_last), 32'(k == n - 1));
        k++;
      end
      prev_stall = ifc.dataOut_val && !rdy;
      prev_data  = ifc.dataOut;
      prev_last  = ifc.dataOut_last;
      @(negedge clk);
      cyc++;
    end
    if (k < n) check($sformatf("timeout_p%0d", pkt_no), 32'(k), 32'(n));
    else model_seq[stream] = model_seq[stream] + 32'd1;
    if (mode == 0) check($sformatf("duration_p%0d", pkt_no), 32'(cyc), 32'(n));
    if (mode == 2) check($sformatf("stall_cycles_p%0d", pkt_no), 32'(stall_cnt), 32'd3);
    check($sformatf("idle_val_p%0d", pkt_no), 32'(ifc.dataOut_val), 32'd0);
    check($sformatf("idle_data_p%0d", pkt_no), ifc.dataOut, 32'd0);
    check($sformatf("idle_last_p%0d", pkt_no), 32'(ifc.dataOut_last), 32'd0);
    check($sformatf("idle_ready_p%0d", pkt_no), 32'(ifc.payloadIn_ready), 32'd1);
    ifc.dataOut_ready = 1'b0;
  endtask

  task automatic drop_req(input int len, input int stream);
    @(negedge clk);
    ifc.payloadLen    = 6'(len);
    ifc.streamId      = SW'(stream);
    ifc.payloadIn_val = 1'b1;
    @(negedge clk);
    ifc.payloadIn_val = 1'b0;
    check($sformatf("drop_pulse_len%0d", len), 32'(ifc.reqDropped), 32'd1);
    check($sformatf("drop_noval_len%0d", len), 32'(ifc.dataOut_val), 32'd0);
    check($sformatf("drop_ready_len%0d", len), 32'(ifc.payloadIn_ready), 32'd1);
    @(negedge clk);
    check($sformatf("drop_end_len%0d", len), 32'(ifc.reqDropped), 32'd0);
    check($sformatf("drop_noval2_len%0d", len), 32'(ifc.dataOut_val), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int streams [5] = '{0, 3, 5, 7, 31};
    reset_b           = 1'b0;
    ifc.payloadIn     = '0;
    ifc.payloadLen    = '0;
    ifc.streamId      = '0;
    ifc.payloadIn_val = 1'b0;
    ifc.dataOut_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ifc.payloadIn_ready), 32'd1);
    check("rst_val",   32'(ifc.dataOut_val), 32'd0);
    check("rst_data",  ifc.dataOut, 32'd0);
    check("rst_last",  32'(ifc.dataOut_last), 32'd0);
    check("rst_drop",  32'(ifc.reqDropped), 32'd0);
    reset_b = 1'b1;

    // Directed: basic frames, sequence advance, boundary lengths, backpressure.
    run_packet(5, 3, 0);
    run_packet(5, 3, 0);
    run_packet(9, 7, 0);
    run_packet(37, 0, 0);
    run_packet(1, 31, 0);
    run_packet(4, 31, 0);
    run_packet(36, 31, 0);
    run_packet(12, 3, 2);

    // Illegal lengths leave the counter of a fresh stream at zero.
    drop_req(0, 9);
    drop_req(38, 9);
    drop_req(63, 9);
    run_packet(8, 9, 0);

    // Randomized traffic with random backpressure and occasional drops.
    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 7) == 0) drop_req(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(38, 63), streams[$urandom_range(0, 4)]);
      run_packet($urandom_range(1, 37), streams[$urandom_range(0, 4)], 1);
    end

    // Reset in the middle of DATA word 1 abandons the frame at once.
    @(negedge clk);
    ifc.payloadLen    = 6'd20;
    ifc.streamId      = SW'(5);
    ifc.payloadIn_val = 1'b1;
    @(negedge clk);
    ifc.payloadIn_val = 1'b0;
    ifc.dataOut_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_val", 32'(ifc.dataOut_val), 32'd1);
    reset_b = 1'b0;
    #1;
    check("mid_rst_val",   32'(ifc.dataOut_val), 32'd0);
    check("mid_rst_data",  ifc.dataOut, 32'd0);
    check("mid_rst_last",  32'(ifc.dataOut_last), 32'd0);
    check("mid_rst_ready", 32'(ifc.payloadIn_ready), 32'd1);
    ifc.dataOut_ready = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    clear_model();

    // After reset every stream restarts at sequence 0.
    run_packet(6, 5, 0);
    run_packet(6, 5, 1);
    run_packet(6, 5, 0);
    run_packet(2, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
